spi_master_tx: RTL and testbench

- Byte-oriented SPI transmitter that generates the serial clock and data consumed by the downstream SPI receiver (inputs i_CLK, i_MOSI).
- Receiver has no chip select: it shifts MSB-first on every SCLK rising edge and treats each 8th edge as a byte boundary. This block must therefore emit exactly 8 rising edges per byte, with no glitches.
- A small TX FIFO decouples the system-side writer from the serial rate.

---
 rtl/spi_pkg.sv | 11 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/spi_master_tx.sv | 84 ++++++++
 tb/tb_spi_master_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame width, FSM state encoding and pointer-width helper.
package spi_pkg;
  localparam int SPI_BITS = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
module sync_fifo import spi_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_full, r_empty, w_push, w_pop;
  assign w_push    = i_push & ~r_full;
  assign w_pop     = i_pop & (r_cnt != '0);
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  assign o_data    = r_mem[r_rd];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  // full anticipates the next count so a write can never overrun; empty lags one cycle
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_cnt_nxt == CW'(DEPTH);
      r_empty <= r_cnt == '0;
    end
endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: FIFO-fed, MSB-first SPI transmitter emitting exactly 8 SCLK rises per byte.
module spi_master_tx import spi_pkg::*; #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_w_en,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_CLK,
  output logic       o_MOSI
);
  localparam int DW = clog2(CLK_DIV) + 1;
  localparam int GW = clog2(GAP_CYCLES + 1) + 1;
  state_t              r_state, w_next;
  logic [DW-1:0]       r_div;
  logic [2:0]          r_bit;
  logic [GW-1:0]       r_gap;
  logic [SPI_BITS-1:0] r_shift, w_fifo_data;
  logic                r_clk, r_mosi, r_busy;
  logic                w_pop, w_div_end, w_last, w_fall, w_gap_end;
  sync_fifo #(.WIDTH(SPI_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .i_push (i_w_en),
    .i_pop  (w_pop),
    .i_data (i_data),
    .o_data (w_fifo_data),
    .o_full (o_full),
    .o_empty(o_empty)
  );
  assign w_div_end = r_div == DW'(CLK_DIV - 1);
  assign w_last    = r_bit == 3'(SPI_BITS - 1);
  assign w_fall    = (r_state == SHIFT) & w_div_end & r_clk;
  assign w_gap_end = r_gap == GW'(GAP_CYCLES - 1);
  assign o_CLK     = r_clk;
  assign o_MOSI    = r_mosi;
  assign o_busy    = r_busy;
  always_comb begin
    w_pop  = (r_state == IDLE) & ~o_empty;
    w_next = r_state == IDLE  ? (o_empty ? IDLE : LOAD) :
             r_state == LOAD  ? SHIFT :
             r_state == SHIFT ? ((w_fall & w_last) ? (GAP_CYCLES == 0 ? IDLE : GAP) : SHIFT) :
                                (w_gap_end ? IDLE : GAP);
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_shift <= '0;
      r_clk   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      // stay busy across the single IDLE cycle between back-to-back frames
      r_busy  <= (w_next != IDLE) | ((r_state != IDLE) & ~o_empty);
      r_gap   <= r_state == GAP ? r_gap + GW'(1) : '0;
      if (w_pop) r_shift <= w_fifo_data;
      if (r_state == LOAD) begin
        r_mosi <= r_shift[SPI_BITS-1];
        r_div  <= '0;
        r_bit  <= '0;
        r_clk  <= 1'b0;
      end
      if (r_state == SHIFT) begin
        r_div <= w_div_end ? '0 : r_div + DW'(1);
        if (w_div_end) r_clk <= ~r_clk;
        if (w_fall) begin
          r_bit <= r_bit + 3'd1;
          if (!w_last) begin
            r_shift <= {r_shift[SPI_BITS-2:0], 1'b0};
            r_mosi  <= r_shift[SPI_BITS-2];
          end
        end
      end
    end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed/random checks of spi_master_tx against a receiver model.
module tb_spi_master_tx;
  localparam int D = 2, G = 4, PER = 16 * D + G + 2, DEPTH = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n = 1'b0, w_en = 1'b0, w_en2 = 1'b0;
  logic [7:0] data = '0, data2 = '0;
  logic       full, empty, busy, sclk, mosi;
  logic       full2, empty2, busy2, sclk2, mosi2;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  spi_master_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_data(data), .i_w_en(w_en), .o_full(full),
    .o_empty(empty), .o_busy(busy), .o_CLK(sclk), .o_MOSI(mosi));
  spi_master_tx #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_data(data2), .i_w_en(w_en2), .o_full(full2),
    .o_empty(empty2), .o_busy(busy2), .o_CLK(sclk2), .o_MOSI(mosi2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic wr(input logic [7:0] d);
    data = d; w_en = 1'b1; step(); w_en = 1'b0;
  endtask
  // receiver models: sample MOSI on every SCLK rise, a byte per 8 rises
  int rise_q[$], rise2_q[$];
  logic [7:0] rx_q[$], rx2_q[$];
  logic p_clk = 0, p_mosi = 0, p_clk2 = 0;
  logic [7:0] sh = '0, sh2 = '0;
  int nb = 0, nb2 = 0, last_chg = 0, last_rise = -1000, last_fall2 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_clk = 0; p_mosi = mosi; nb = 0; p_clk2 = 0; nb2 = 0;
    end else begin
      if (mosi !== p_mosi) begin
        chk("mosi_hold", 32'(cyc - last_rise >= D), 1);
        last_chg = cyc;
      end
      if (sclk && !p_clk) begin
        chk("mosi_setup", 32'(cyc - last_chg >= D), 1);
        rise_q.push_back(cyc); last_rise = cyc;
        sh = {sh[6:0], mosi}; nb++;
        if (nb == 8) begin rx_q.push_back(sh); nb = 0; end
      end
      if (sclk2 && !p_clk2) begin
        rise2_q.push_back(cyc);
        sh2 = {sh2[6:0], mosi2}; nb2++;
        if (nb2 == 8) begin rx2_q.push_back(sh2); nb2 = 0; end
      end
      if (!sclk2 && p_clk2) last_fall2 = cyc;
      p_clk = sclk; p_mosi = mosi; p_clk2 = sclk2;
    end
  end
  initial begin
    int w0, n, mcnt;
    logic seen, drop;
    logic [7:0] b[4], exp_q[$], ov[5];
    step(2);
    chk("rst_clk", sclk, 0); chk("rst_mosi", mosi, 0); chk("rst_busy", busy, 0);
    chk("rst_full", full, 0); chk("rst_empty", empty, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin step(); chk("idle", {sclk, busy, empty}, 3'b001); end
    // single byte
    w0 = cyc + 1; wr(8'hA5);
    for (int i = 0; i < 300 && rx_q.size() < 1; i++) step();
    for (int i = 0; i < 300 && busy; i++) step();
    step(2);
    chk("a5_count", rx_q.size(), 1); chk("a5_rises", rise_q.size(), 8);
    if (rx_q.size() > 0) chk("a5_byte", rx_q[0], 8'hA5);
    if (rise_q.size() == 8) begin
      chk("a5_first_rise", rise_q[0] - w0, 3 + D);
      for (int i = 1; i < 8; i++) chk("a5_period", rise_q[i] - rise_q[i-1], 2 * D);
    end
    chk("a5_busy_end", busy, 0); chk("a5_empty_end", empty, 1);
    // back-to-back random bytes
    rise_q.delete(); rx_q.delete();
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    w0 = cyc + 1;
    for (int i = 0; i < 4; i++) wr(b[i]);
    seen = 0; drop = 0;
    for (int i = 0; i < 1000 && rx_q.size() < 4; i++) begin
      step();
      if (busy) seen = 1; else if (seen && rx_q.size() < 4) drop = 1;
    end
    chk("b2b_busy_seen", seen, 1); chk("b2b_busy_drop", drop, 0);
    chk("b2b_count", rx_q.size(), 4);
    if (rx_q.size() == 4 && rise_q.size() == 32) begin
      for (int i = 0; i < 4; i++) chk("b2b_byte", rx_q[i], b[i]);
      chk("b2b_first_rise", rise_q[0] - w0, 3 + D);
      for (int k = 1; k < 4; k++) chk("b2b_frame_period", rise_q[8*k] - rise_q[8*k-8], PER);
    end
    for (int i = 0; i < 300 && busy; i++) step();
    // overflow while a frame is in flight (no pops can happen)
    rise_q.delete(); rx_q.delete(); exp_q.delete();
    b[0] = 8'($urandom); exp_q.push_back(b[0]); wr(b[0]);
    for (int i = 0; i < 20 && !busy; i++) step();
    chk("ovf_busy", busy, 1);
    mcnt = 0;
    for (int i = 0; i < 5; i++) begin
      ov[i] = 8'h10 + 8'(i);
      if (mcnt < DEPTH) begin exp_q.push_back(ov[i]); mcnt++; end
      wr(ov[i]);
      if (i == 2) chk("ovf_not_full", full, 0);
      if (i >= 3) chk("ovf_full", full, 1);
    end
    for (int i = 0; i < 2000 && rx_q.size() < exp_q.size(); i++) step();
    for (int i = 0; i < 300 && busy; i++) step();
    step(20);
    chk("ovf_count", rx_q.size(), exp_q.size());
    if (rx_q.size() == exp_q.size())
      foreach (exp_q[i]) chk("ovf_byte", rx_q[i], exp_q[i]);
    // reset mid-frame
    rise_q.delete(); rx_q.delete();
    wr(8'hFF);
    for (int i = 0; i < 300 && rise_q.size() < 3; i++) step();
    chk("mid_rises", rise_q.size(), 3); chk("mid_clk_high", sclk, 1); chk("mid_mosi_high", mosi, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_clk", sclk, 0); chk("mid_rst_mosi", mosi, 0); chk("mid_rst_busy", busy, 0);
    step(2); rst_n = 1'b1;
    n = rise_q.size();
    step(200);
    chk("mid_no_sclk", rise_q.size(), n); chk("mid_empty", empty, 1);
    chk("mid_sclk_low", sclk, 0); chk("mid_no_byte", rx_q.size(), 0);
    // minimum divider, no gap
    w0 = cyc + 1; data2 = 8'h3C; w_en2 = 1'b1; step(); w_en2 = 1'b0;
    for (int i = 0; i < 200 && rx2_q.size() < 1; i++) step();
    step(5);
    chk("min_count", rx2_q.size(), 1); chk("min_rises", rise2_q.size(), 8);
    if (rx2_q.size() == 1) chk("min_byte", rx2_q[0], 8'h3C);
    if (rise2_q.size() == 8) begin
      chk("min_first_rise", rise2_q[0] - w0, 4);
      for (int i = 1; i < 8; i++) chk("min_period", rise2_q[i] - rise2_q[i-1], 2);
    end
    chk("min_last_fall", last_fall2 - w0, 19);
    chk("min_busy_end", busy2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
